iot_pio_shift_out: RTL and testbench
====================================

IOT_PIO_SHIFT_OUT -- requirements
Module: iot_pio_shift_out

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per serial phase (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pio_in  input  4  control word from the 4-bit PIO out_port, same clock domain, no synchronizer.
REQ-005 SHALL have port refresh  input  1  one-cycle request to resend the current word even if unchanged.
REQ-006 SHALL have port ser_data  output  1  serial data to the external shift register, MSB first.
REQ-007 SHALL have port ser_clk  output  1  serial shift clock; external device samples ser_data on its rising edge.
REQ-008 SHALL have port ser_latch  output  1  storage-latch strobe, high for CLK_DIV cycles after the last bit.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress (any non-IDLE state).
REQ-010 SHALL have port done  output  1  one-cycle pulse on frame completion.
REQ-011 SHALL have port frame_count  output  8  count of completed frames, wraps 255->0.

Function
REQ-012 SHALL implement states IDLE, SHIFT_LO, SHIFT_HI and LATCH; all outputs SHALL be registered.
REQ-013 SHALL keep a 4-bit shadow register holding the last word sent.
REQ-014 SHALL set refresh_pend when refresh=1 in any state; refresh_pend SHALL be cleared only on a frame start.
REQ-015 SHALL start a frame in IDLE when pio_in != shadow or refresh_pend=1: on that cycle load shift_reg<=pio_in, shadow<=pio_in, bit_cnt<=3, div_cnt<=0, and enter SHIFT_LO.
REQ-016 SHALL drive busy=1 from the cycle after the start cycle until the cycle IDLE is re-entered.
REQ-017 SHALL hold SHIFT_LO for exactly CLK_DIV cycles with ser_clk=0 and ser_data=shift_reg[3], then enter SHIFT_HI.
REQ-018 SHALL hold SHIFT_HI for exactly CLK_DIV cycles with ser_clk=1 and ser_data held stable.
REQ-019 SHALL leave SHIFT_HI as follows: if bit_cnt=0, enter LATCH; otherwise shift shift_reg left by one, decrement bit_cnt and enter SHIFT_LO.
REQ-020 SHALL hold LATCH for exactly CLK_DIV cycles with ser_clk=0 and ser_latch=1.
REQ-021 SHALL, on leaving LATCH, return to IDLE, increment frame_count (modulo 256) and pulse done=1 for exactly one cycle.
REQ-022 SHALL keep each frame exactly 9*CLK_DIV cycles in non-IDLE states, regardless of pio_in activity.
REQ-023 SHALL sample pio_in only on the start cycle; changes during a frame SHALL NOT alter the bits being shifted.
REQ-024 SHALL spend at least one cycle in IDLE between frames; a change or refresh seen during a frame SHALL start the next frame on the first IDLE cycle's evaluation, sending the latest pio_in.
REQ-025 SHALL coalesce multiple pio_in changes and refresh pulses during one frame into a single follow-up frame.
REQ-026 SHALL, in IDLE, drive ser_clk=0, ser_latch=0 and hold ser_data at its last value.

Reset
REQ-027 SHALL, while reset_n=0, force state=IDLE and clear ser_data, ser_clk, ser_latch, busy, done, frame_count, shadow, shift_reg, bit_cnt, div_cnt and refresh_pend to 0.
REQ-028 SHALL abort any frame asserted into reset mid-operation without a latch pulse, and SHALL NOT emit a frame after release while pio_in=0.

Verification (CLK_DIV=2 unless stated)
REQ-029 SHALL verify a basic frame: pio_in 0->4'b1010 -> ser_data at the 4 ser_clk rising edges = 1,0,1,0; ser_latch high 2 cycles; busy high 18 cycles; done pulses once; frame_count=1.
REQ-030 SHALL verify a mid-frame change: pio_in=4'h3, then 4'hC, then 4'h5 during the frame -> first frame shifts 0011, exactly one follow-up frame shifts 0101, frame_count=2.
REQ-031 SHALL verify refresh: refresh pulse with pio_in=shadow=4'h6 -> one frame shifting 0110; a second refresh during that frame -> exactly one additional frame.
REQ-032 SHALL verify wrap: 256 frames -> frame_count=0 and done count=256.
REQ-033 SHALL verify reset mid-frame: reset_n low in SHIFT_HI of bit 2 -> all outputs 0, no ser_latch; after release with pio_in=4'h9 -> one full frame shifting 1001.
REQ-034 SHALL verify CLK_DIV=1: pio_in 4'hF -> ser_clk toggles every cycle, frame spans 9 cycles, ser_latch high 1 cycle.

Source files
------------

// File: rtl/iot_pio_shift_out.sv
// ---------------------------------------------------------------------------
// iot_pio_shift_out
//
// Serialises a 4-bit PIO control word into an external serial-in/parallel-out
// shift register (e.g. a 74HC595-style part). A frame is sent whenever the
// PIO word differs from the last word sent, or when a resend is requested.
// A frame shifts 4 bits MSB first, then strobes the storage latch.
// Each serial phase (clock low, clock high, latch) lasts CLK_DIV cycles.
//
// Parameters
//   CLK_DIV      clk cycles per serial phase (1..65535)
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   pio_in       4-bit control word from the PIO out_port (same clock domain)
//   refresh      one-cycle request to resend the current word
//   ser_data     serial data, MSB first
//   ser_clk      shift clock; the external device samples on its rising edge
//   ser_latch    storage-latch strobe, high for CLK_DIV cycles after bit 0
//   busy         high while a frame is in progress
//   done         one-cycle pulse when a frame completes
//   frame_count  completed-frame counter, wraps 255 -> 0
// ---------------------------------------------------------------------------
module iot_pio_shift_out #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] pio_in,
    input  logic       refresh,
    output logic       ser_data,
    output logic       ser_clk,
    output logic       ser_latch,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      state;
    logic [3:0]  shadow;
    logic [3:0]  shift_reg;
    logic [1:0]  bit_cnt;
    logic [15:0] div_cnt;
    logic        refresh_pend;
    logic        phase_end;

    // Last cycle of the current CLK_DIV-long phase.
    assign phase_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ser_data     <= 1'b0;
            ser_clk      <= 1'b0;
            ser_latch    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            frame_count  <= 8'd0;
            shadow       <= 4'd0;
            shift_reg    <= 4'd0;
            bit_cnt      <= 2'd0;
            div_cnt      <= 16'd0;
            refresh_pend <= 1'b0;
        end else begin
            done <= 1'b0;

            // A refresh is remembered in every state; a frame start below
            // overrides this, since that frame already sends the current word.
            if (refresh) begin
                refresh_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    ser_clk   <= 1'b0;
                    ser_latch <= 1'b0;
                    if ((pio_in != shadow) || refresh_pend) begin
                        // pio_in is captured only here; later changes wait
                        // for the next frame.
                        shift_reg    <= pio_in;
                        shadow       <= pio_in;
                        bit_cnt      <= 2'd3;
                        div_cnt      <= 16'd0;
                        refresh_pend <= 1'b0;
                        ser_data     <= pio_in[3];
                        busy         <= 1'b1;
                        state        <= SHIFT_LO;
                    end
                end

                SHIFT_LO: begin
                    ser_data <= shift_reg[3];
                    if (phase_end) begin
                        div_cnt <= 16'd0;
                        ser_clk <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end

                SHIFT_HI: begin
                    if (phase_end) begin
                        div_cnt <= 16'd0;
                        ser_clk <= 1'b0;
                        if (bit_cnt == 2'd0) begin
                            ser_latch <= 1'b1;
                            state     <= LATCH;
                        end else begin
                            // Present the next bit together with the falling
                            // edge so it is stable for the whole low phase.
                            shift_reg <= {shift_reg[2:0], 1'b0};
                            ser_data  <= shift_reg[2];
                            bit_cnt   <= bit_cnt - 2'd1;
                            state     <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end

                LATCH: begin
                    if (phase_end) begin
                        div_cnt     <= 16'd0;
                        ser_latch   <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                        state       <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iot_pio_shift_out.sv
// ---------------------------------------------------------------------------
// tb_iot_pio_shift_out
//
// Self-checking bench for iot_pio_shift_out. Two instances run side by side:
// dut (CLK_DIV=2) and dut1 (CLK_DIV=1). A frame-level model predicts every
// output cycle by cycle from the frame start time and the captured word;
// directed scenarios add hand-computed expectations (bit sequence seen at
// ser_clk rising edges, latch/busy lengths, done counts, frame_count).
// Inputs change on the falling edge; outputs are sampled 2 time units after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_iot_pio_shift_out;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] pio = 4'd0;
    logic       refresh = 1'b0;
    logic [3:0] pio1 = 4'd0;
    logic       refresh1 = 1'b0;

    logic       ser_data, ser_clk, ser_latch, busy, done;
    logic [7:0] frame_count;
    logic       ser_data_1, ser_clk_1, ser_latch_1, busy_1, done_1;
    logic [7:0] frame_count_1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iot_pio_shift_out #(.CLK_DIV(2)) dut (
        .clk(clk), .reset_n(reset_n), .pio_in(pio), .refresh(refresh),
        .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch),
        .busy(busy), .done(done), .frame_count(frame_count)
    );

    iot_pio_shift_out #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .pio_in(pio1), .refresh(refresh1),
        .ser_data(ser_data_1), .ser_clk(ser_clk_1), .ser_latch(ser_latch_1),
        .busy(busy_1), .done(done_1), .frame_count(frame_count_1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // k = output cycle index within a frame (1..9*d); phase = (k-1)/d:
    // phases 0..7 alternate clock low/high for bits 3..0, phase 8 is latch.
    typedef struct packed {
        logic        active;
        logic [15:0] k;
        logic [3:0]  word;
        logic [3:0]  shadow;
        logic        pend;
        logic [7:0]  count;
        logic        done;
        logic        data;
    } mdl_t;

    mdl_t m0 = '0;
    mdl_t m1 = '0;

    function automatic int phase_of(mdl_t s, int d);
        return (int'(s.k) - 1) / d;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, logic [3:0] p, logic rf, int d);
        mdl_t n = s;
        int   ph;
        n.done = 1'b0;
        if (s.active) begin
            n.k = s.k + 16'd1;
            if (int'(n.k) > 9 * d) begin
                n.active = 1'b0;
                n.done   = 1'b1;
                n.count  = s.count + 8'd1;
            end
            if (rf) n.pend = 1'b1;
        end else if ((p != s.shadow) || s.pend) begin
            n.active = 1'b1;
            n.k      = 16'd1;
            n.word   = p;
            n.shadow = p;
            n.pend   = 1'b0;
        end else if (rf) begin
            n.pend = 1'b1;
        end
        if (n.active) begin
            ph = phase_of(n, d);
            n.data = (ph < 8) ? n.word[3 - ph / 2] : n.word[0];
        end
        return n;
    endfunction

    function automatic logic exp_clk(mdl_t s, int d);
        int ph = phase_of(s, d);
        return s.active && (ph < 8) && (ph % 2 == 1);
    endfunction

    function automatic logic exp_latch(mdl_t s, int d);
        return s.active && (phase_of(s, d) == 8);
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m0 = '0;
            m1 = '0;
        end else begin
            m0 = mdl_step(m0, pio, refresh, 2);
            m1 = mdl_step(m1, pio1, refresh1, 1);
        end
    end

    // ---------------- monitors / per-cycle compare ----------------
    logic        prev_clk0 = 1'b0, prev_clk1 = 1'b0;
    logic [31:0] bits0 = '0, bits1 = '0;
    int bits_n0 = 0, bits_n1 = 0;
    int latch_cnt0 = 0, busy_cnt0 = 0, done_cnt0 = 0;
    int latch_cnt1 = 0, busy_cnt1 = 0, done_cnt1 = 0;

    always begin
        @(posedge clk);
        #2;
        check("m_data",    {31'd0, ser_data},    {31'd0, m0.data});
        check("m_clk",     {31'd0, ser_clk},     {31'd0, exp_clk(m0, 2)});
        check("m_latch",   {31'd0, ser_latch},   {31'd0, exp_latch(m0, 2)});
        check("m_busy",    {31'd0, busy},        {31'd0, m0.active});
        check("m_done",    {31'd0, done},        {31'd0, m0.done});
        check("m_count",   {24'd0, frame_count}, {24'd0, m0.count});
        check("m1_data",   {31'd0, ser_data_1},    {31'd0, m1.data});
        check("m1_clk",    {31'd0, ser_clk_1},     {31'd0, exp_clk(m1, 1)});
        check("m1_latch",  {31'd0, ser_latch_1},   {31'd0, exp_latch(m1, 1)});
        check("m1_busy",   {31'd0, busy_1},        {31'd0, m1.active});
        check("m1_done",   {31'd0, done_1},        {31'd0, m1.done});
        check("m1_count",  {24'd0, frame_count_1}, {24'd0, m1.count});

        if (ser_clk && !prev_clk0) begin
            bits0 = {bits0[30:0], ser_data};
            bits_n0++;
        end
        if (ser_clk_1 && !prev_clk1) begin
            bits1 = {bits1[30:0], ser_data_1};
            bits_n1++;
        end
        prev_clk0 = ser_clk;
        prev_clk1 = ser_clk_1;
        if (ser_latch)   latch_cnt0++;
        if (busy)        busy_cnt0++;
        if (done)        done_cnt0++;
        if (ser_latch_1) latch_cnt1++;
        if (busy_1)      busy_cnt1++;
        if (done_1)      done_cnt1++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic clr();
        bits0 = '0; bits1 = '0; bits_n0 = 0; bits_n1 = 0;
        latch_cnt0 = 0; busy_cnt0 = 0; done_cnt0 = 0;
        latch_cnt1 = 0; busy_cnt1 = 0; done_cnt1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pio = 4'd0; refresh = 1'b0; pio1 = 4'd0; refresh1 = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clr();
    endtask

    task automatic wait_done(input int target, input int max_cycles, input string name);
        int i = 0;
        while (done_cnt0 < target && i < max_cycles) begin
            @(negedge clk);
            i++;
        end
        if (done_cnt0 < target) check(name, 32'd0, 32'd1);
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    initial begin
        int t;

        // Reset state and no spurious frame with pio_in = 0.
        do_reset();
        #1;
        check("rst_data",  {31'd0, ser_data},  32'd0);
        check("rst_clk",   {31'd0, ser_clk},   32'd0);
        check("rst_latch", {31'd0, ser_latch}, 32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_count", {24'd0, frame_count}, 32'd0);
        repeat (10) @(negedge clk);
        check("idle_no_frame", busy_cnt0, 32'd0);
        $display("[TB] reset/idle checked");

        // Basic frame 4'b1010.
        pio = 4'b1010;
        wait_done(1, 40, "basic_timeout");
        repeat (5) @(negedge clk);
        check("basic_bits",  bits0, 32'hA);
        check("basic_nbits", bits_n0, 32'd4);
        check("basic_latch", latch_cnt0, 32'd2);
        check("basic_busy",  busy_cnt0, 32'd18);
        check("basic_done",  done_cnt0, 32'd1);
        check("basic_count", {24'd0, frame_count}, 32'd1);
        $display("[TB] basic frame 1010: bits=%0h", bits0);

        // Mid-frame changes coalesce into one follow-up frame.
        do_reset();
        pio = 4'h3;
        repeat (3) @(negedge clk);
        pio = 4'hC;
        repeat (3) @(negedge clk);
        pio = 4'h5;
        wait_done(2, 100, "mid_timeout");
        repeat (30) @(negedge clk);
        check("mid_bits",  bits0, 32'h35);
        check("mid_nbits", bits_n0, 32'd8);
        check("mid_done",  done_cnt0, 32'd2);
        check("mid_count", {24'd0, frame_count}, 32'd2);
        $display("[TB] mid-frame change: bits=%0h", bits0);

        // Refresh with unchanged word, plus one refresh during that frame.
        do_reset();
        pio = 4'h6;
        wait_done(1, 40, "ref_pre_timeout");
        repeat (2) @(negedge clk);
        clr();
        pulse_refresh();
        repeat (4) @(negedge clk);
        pulse_refresh();
        wait_done(2, 100, "ref_timeout");
        repeat (30) @(negedge clk);
        check("ref_bits",  bits0, 32'h66);
        check("ref_nbits", bits_n0, 32'd8);
        check("ref_done",  done_cnt0, 32'd2);
        check("ref_count", {24'd0, frame_count}, 32'd3);
        $display("[TB] refresh: bits=%0h", bits0);

        // 256 frames wrap frame_count back to 0.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            pulse_refresh();
            wait_done(i + 1, 40, "wrap_timeout");
        end
        repeat (3) @(negedge clk);
        check("wrap_count", {24'd0, frame_count}, 32'd0);
        check("wrap_done",  done_cnt0, 32'd256);
        $display("[TB] wrap: done=%0d count=%0d", done_cnt0, frame_count);

        // Reset asserted in SHIFT_HI of the second bit aborts the frame.
        do_reset();
        pio = 4'hF;
        t = 0;
        while (bits_n0 < 2 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("abort_reach_hi", bits_n0, 32'd2);
        check("abort_in_hi",    {31'd0, ser_clk}, 32'd1);
        reset_n = 1'b0;
        pio = 4'h9;
        #1;
        check("abort_data",  {31'd0, ser_data},  32'd0);
        check("abort_clk",   {31'd0, ser_clk},   32'd0);
        check("abort_latch", {31'd0, ser_latch}, 32'd0);
        check("abort_busy",  {31'd0, busy},      32'd0);
        check("abort_done",  {31'd0, done},      32'd0);
        check("abort_count", {24'd0, frame_count}, 32'd0);
        repeat (2) @(negedge clk);
        check("abort_no_latch", latch_cnt0, 32'd0);
        reset_n = 1'b1;
        clr();
        wait_done(1, 40, "abort_timeout");
        repeat (10) @(negedge clk);
        check("abort_bits",   bits0, 32'h9);
        check("abort_nbits",  bits_n0, 32'd4);
        check("abort_latch2", latch_cnt0, 32'd2);
        check("abort_done2",  done_cnt0, 32'd1);
        check("abort_count2", {24'd0, frame_count}, 32'd1);
        $display("[TB] reset mid-frame then 1001: bits=%0h", bits0);

        // CLK_DIV = 1 instance.
        do_reset();
        pio1 = 4'hF;
        repeat (15) @(negedge clk);
        check("div1_bits",  bits1, 32'hF);
        check("div1_rises", bits_n1, 32'd4);
        check("div1_busy",  busy_cnt1, 32'd9);
        check("div1_latch", latch_cnt1, 32'd1);
        check("div1_done",  done_cnt1, 32'd1);
        check("div1_count", {24'd0, frame_count_1}, 32'd1);
        $display("[TB] CLK_DIV=1 frame F: busy=%0d latch=%0d", busy_cnt1, latch_cnt1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
